// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble)
// method, one bit per clock. Results drive a multiplexed 7-segment display:
// bcd/ovf/blank only change when a conversion completes, so the display
// never shows intermediate scratch values.
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // Largest value representable in DIGITS decimal digits.
    localparam logic [63:0] MAX_VAL  = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] BIN_MAX  = (64'd1 << WIDTH) - 64'd1;
    // When every WIDTH-bit value fits, overflow detection collapses to 0.
    localparam bit          NEED_OVF = (BIN_MAX > MAX_VAL);
    // Reset/idle blanking: all digits above the units are leading zeros.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pend;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   next_scratch;
    logic [DIGITS-1:0]  next_blank;
    logic               zero_run;

    assign busy = (state == SHIFT);

    // Add-3 correction on each digit >= 5, then shift in the next binary MSB;
    // also derive leading-zero blanking from the resulting digits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        adj        = scratch;
        next_blank = '0;
        zero_run   = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
        next_scratch = (adj << 1) | BCD_W'(sreg[WIDTH-1]);
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run      = zero_run & (next_scratch[4*d +: 4] == 4'd0);
            next_blank[d] = zero_run;
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state    <= IDLE;
            sreg     <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
            blank    <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg     <= bin;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= NEED_OVF && (64'(bin) > MAX_VAL);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        if (ovf_pend) begin
                            bcd   <= '1;
                            ovf   <= 1'b1;
                            blank <= '0;
                        end else begin
                            bcd   <= next_scratch;
                            ovf   <= 1'b0;
                            blank <= next_blank;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (WIDTH=14, DIGITS=4). Expected results
// come from a decimal model, are queued when a start is driven and are popped
// when done is seen.
module tb_bin2bcd_seq;

    localparam int W = 14;
    localparam int D = 4;

    typedef struct {
        logic [4*D-1:0] bcd;
        logic           ovf;
        logic [D-1:0]   blank;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   bin;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;
    logic           ovf;
    logic [D-1:0]   blank;

    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_err = 0;

    bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference model.
    function automatic exp_t model(input int v);
        exp_t e;
        int   p;
        if (v > 9999) begin
            e.bcd   = '1;
            e.ovf   = 1'b1;
            e.blank = '0;
        end else begin
            e.bcd   = '0;
            e.ovf   = 1'b0;
            e.blank = '0;
            p = 1;
            for (int k = 0; k < D; k++) begin
                e.bcd[4*k +: 4] = 4'((v / p) % 10);
                if (k >= 1 && v < p) e.blank[k] = 1'b1;
                p = p * 10;
            end
        end
        return e;
    endfunction

    function automatic exp_t reset_out();
        exp_t e;
        e.bcd   = '0;
        e.ovf   = 1'b0;
        e.blank = 4'b1110;
        return e;
    endfunction

    task automatic push_exp(input int v);
        sb.push_back(model(v));
    endtask

    // Present start for exactly one edge (E0); leaves the bench at the
    // falling edge after E0.
    task automatic drive_start(input int v);
        bin   = v[W-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_ack: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
    endtask

    // Wait (bounded) for done; n0 = edges already elapsed since E0.
    // Returns at the falling edge where done is high.
    task automatic wait_result(input string name, input int n0);
        int   n;
        bit   busy_bad;
        bit   hold_bad;
        exp_t e;
        n        = n0;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        while (done !== 1'b1 && n < W + 10) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (bcd !== last.bcd || ovf !== last.ovf || blank !== last.blank) hold_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != W) begin
            n_err++;
            $display("FAIL %s latency: done after %0d edges, required %0d", name, n, W);
        end
        n_cmp++;
        if (busy_bad) begin
            n_err++;
            $display("FAIL %s busy: busy dropped before done, required high throughout", name);
        end
        n_cmp++;
        if (hold_bad) begin
            n_err++;
            $display("FAIL %s hold: outputs changed during conversion, required %h/%b/%b",
                     name, last.bcd, last.ovf, last.blank);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_end: busy=%b with done, required 0", name, busy);
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard: result with no expectation queued", name);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if (bcd !== e.bcd || ovf !== e.ovf || blank !== e.blank) begin
                n_err++;
                $display("FAIL %s result: bcd=%h ovf=%b blank=%b, required bcd=%h ovf=%b blank=%b",
                         name, bcd, ovf, blank, e.bcd, e.ovf, e.blank);
            end
            last = e;
        end
    endtask

    task automatic convert(input string name, input int v);
        push_exp(v);
        drive_start(v);
        wait_result(name, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== '0 || ovf !== 1'b0 || blank !== 4'b1110) begin
            n_err++;
            $display("FAIL %s: busy=%b done=%b bcd=%h ovf=%b blank=%b, required 0 0 0000 0 1110",
                     name, busy, done, bcd, ovf, blank);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        bin   = 14'd1234;
        #1;
        check_reset_outputs("reset_immediate");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_idle_after_release");
        last = reset_out();
    endtask

    task automatic test_basic();
        convert("zero", 0);
        n_cmp++;
        @(negedge clk);
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        convert("v1234", 1234);
        convert("v7", 7);
        convert("v9999", 9999);
    endtask

    task automatic test_overflow();
        convert("v10000", 10000);
        convert("v16383", 16383);
        convert("v5_after_ovf", 5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) convert("random", int'($urandom_range(0, 16383)));
    endtask

    task automatic test_back_to_back();
        push_exp(42);
        drive_start(42);
        repeat (4) @(negedge clk);
        bin   = 14'd999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = '0;
        wait_result("ignore_busy", 5);
        convert("back_to_back", 999);
    endtask

    task automatic test_abort();
        bit done_seen;
        convert("pre_abort", 1234);
        @(negedge clk);
        drive_start(777);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_abort");
        #1 rst = 1'b0;
        last = reset_out();
        done_seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        n_cmp++;
        if (done_seen) begin
            n_err++;
            $display("FAIL abort_no_done: activity seen after abort, required none");
        end
        convert("after_abort", 56);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_random();
        test_back_to_back();
        test_abort();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 14, is the binary input width in bits (legal range 4..20).
REQ-002 Parameter DIGITS, default 4, is the number of BCD output digits (legal range 1..6).
REQ-003 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset is asynchronous and active-high.
REQ-005 Port start, input, 1 bit: conversion request, sampled on the clk edge.
REQ-006 Port bin, input, WIDTH bits: unsigned binary value, sampled together with start.
REQ-007 Port busy, output, 1 bit: conversion in progress.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking that bcd, ovf and blank have been updated.
REQ-009 Port bcd, output, DIGITS*4 bits: result; digit 0 (units) in [3:0], digit k in [4k+3:4k]; each digit feeds one 7-segment decoder input.
REQ-010 Port ovf, output, 1 bit: the last result exceeded 10^DIGITS-1.
REQ-011 Port blank, output, DIGITS bits: bit k high means digit k is a leading zero and is to be blanked by the scan stage.

Function
REQ-012 The block SHALL implement states IDLE and SHIFT; busy SHALL be high exactly when in SHIFT.
REQ-013 In IDLE, start=1 at edge E0 SHALL latch bin into a shift register, clear the DIGITS*4-bit scratch register and the iteration counter, and enter SHIFT.
REQ-014 In IDLE, start=0 SHALL leave all registers unchanged.
REQ-015 Each SHIFT edge SHALL first add 3 to every scratch digit >=5, then shift {scratch, shift register} left by 1 bit, taking the MSB of the binary into scratch bit 0.
REQ-016 After exactly WIDTH SHIFT iterations (edges E1..E_WIDTH), edge E_WIDTH SHALL load bcd, ovf and blank, assert done for one cycle, and return to IDLE.
REQ-017 start SHALL be ignored while busy=1, with no effect on the running conversion or on the latched operand.
REQ-018 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back conversions every WIDTH+1 cycles.
REQ-019 bcd, ovf and blank SHALL hold their previous values throughout a conversion, so the display does not flicker.
REQ-020 Overflow SHALL be decided at E0 by comparing bin with the constant 10^DIGITS-1; if bin is greater, the result SHALL be bcd with every digit set to 4'hF (the decoder renders a dash), ovf=1 and blank all zero.
REQ-021 A result that is not an overflow SHALL set ovf=0 and bcd equal to the scratch register.
REQ-022 blank bit k (k>=1) SHALL be 1 iff digit k and every digit above it is zero.
REQ-023 blank bit 0 SHALL always be 0, so a value of 0 displays a single "0".
REQ-024 The scratch arithmetic SHALL stay within 4 bits per digit; a non-overflow input SHALL never carry out of the top digit.
REQ-025 If WIDTH is too small to need overflow detection (2^WIDTH-1 <= 10^DIGITS-1), ovf SHALL be constant 0.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL be in IDLE with busy=0, done=0, bcd=0, ovf=0, blank={DIGITS-1 ones, 0}.
REQ-027 Reset during SHIFT SHALL abort the conversion with no done pulse; the first accepted start after release SHALL convert normally.
REQ-028 After rst deasserts, the first start SHALL be honoured on the first clk edge that samples it.

Verification
REQ-029 Scenario: bin=0, start pulse -> busy high for 14 cycles; done pulse at E14; bcd=16'h0000, blank=4'b1110, ovf=0.
REQ-030 Scenario: bin=1234 -> bcd=16'h1234, blank=4'b0000, ovf=0; bin=7 -> bcd=16'h0007, blank=4'b1110.
REQ-031 Scenario: bin=9999 -> bcd=16'h9999, ovf=0; then bin=10000 and bin=16383 -> bcd=16'hFFFF, ovf=1, blank=0.
REQ-032 Scenario: start with bin=42, then start=1 with bin=999 at E5 -> ignored; result 16'h0042 at E14, then a back-to-back start at E15 with bin=999 -> 16'h0999, blank=4'b1000.
REQ-033 Scenario: rst pulsed asynchronously mid-SHIFT (between edges) after an earlier 16'h1234 result -> outputs reset at once to bcd=0, busy=0, blank=4'b1110; no done; a following start with bin=56 -> 16'h0056.
